// File: rtl/pll_loop_filter.sv
// PI loop filter and brake sequencer for the all-digital PLL.
// Define LOOP_FILTER_SAT_EN to clamp accum/dctrl instead of wrapping.
module pll_loop_filter #(
  parameter int ERR_W        = 16,
  parameter int ACC_W        = 24,
  parameter int CODE_W       = 20,
  parameter int KP           = 400,
  parameter int KI           = 60,
  parameter int BRAKE_CODE   = 1666,
  parameter int BRAKE_DIV    = 300,
  parameter int BRAKE_CYCLES = 100,
  parameter int RECOVER_STEP = 4
) (
  input  logic                     refclk,
  input  logic                     reset,
  input  logic                     err_valid,
  input  logic signed [ERR_W-1:0]  err,
  input  logic                     brake,
  output logic signed [CODE_W-1:0] dctrl,
  output logic                     dctrl_valid,
  output logic [15:0]              div_delta,
  output logic [1:0]               brake_state,
  output logic                     sat
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_BRAKING = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(BRAKE_CYCLES + 1);

`ifdef LOOP_FILTER_SAT_EN
  localparam int SUM_W  = ACC_W + 2;
  localparam int PROD_W = ERR_W + ACC_W + 8;
  localparam logic signed [SUM_W-1:0] ACC_HI =
    SUM_W'((longint'(1) <<< (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_LO = -ACC_HI - 1;
  localparam logic signed [PROD_W-1:0] CODE_HI =
    PROD_W'((longint'(1) <<< (CODE_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] CODE_LO = -CODE_HI - 1;
`else
  // Wrapping keeps only the low bits, which these narrow sums give exactly.
  localparam int SUM_W  = ACC_W;
  localparam int PROD_W = CODE_W;
`endif

  logic signed [ACC_W-1:0]  r_accum;
  logic signed [CODE_W-1:0] r_dctrl;
  logic                     r_dv;
  logic                     r_sat;
  logic                     r_kick;
  logic                     r_brake_q;
  logic [15:0]              r_div;
  logic [CNT_W-1:0]         r_count;
  state_t                   r_state;

  logic                     w_rise;
  logic                     w_kick;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [CODE_W-1:0] w_code;
  logic                     w_clip;
  state_t                   w_state_n;
  logic [CNT_W-1:0]         w_count_n;
  logic [15:0]              w_div_n;

  assign w_rise = brake & ~r_brake_q;
  assign w_kick = r_kick | w_rise;

  assign w_sum = SUM_W'(r_accum) + SUM_W'(err)
               - (w_kick ? SUM_W'(BRAKE_CODE) : SUM_W'(0));

  assign w_prod = PROD_W'(KP) * PROD_W'(err)
                + PROD_W'(KI) * PROD_W'(w_acc_next);

`ifdef LOOP_FILTER_SAT_EN
  logic w_acc_clip;
  logic w_code_clip;

  always_comb begin
    w_acc_next = w_sum[ACC_W-1:0];
    w_acc_clip = 1'b0;
    if (w_sum > ACC_HI) begin
      w_acc_next = ACC_HI[ACC_W-1:0];
      w_acc_clip = 1'b1;
    end else if (w_sum < ACC_LO) begin
      w_acc_next = ACC_LO[ACC_W-1:0];
      w_acc_clip = 1'b1;
    end
  end

  always_comb begin
    w_code      = w_prod[CODE_W-1:0];
    w_code_clip = 1'b0;
    if (w_prod > CODE_HI) begin
      w_code      = CODE_HI[CODE_W-1:0];
      w_code_clip = 1'b1;
    end else if (w_prod < CODE_LO) begin
      w_code      = CODE_LO[CODE_W-1:0];
      w_code_clip = 1'b1;
    end
  end

  assign w_clip = w_acc_clip | w_code_clip;
`else
  assign w_acc_next = w_sum;
  assign w_code     = w_prod;
  assign w_clip     = 1'b0;
`endif

  // A brake rise overrides sequencing, even on a sample cycle.
  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_div_n   = r_div;
    if (w_rise) begin
      w_state_n = ST_BRAKING;
      w_count_n = CNT_W'(BRAKE_CYCLES);
      w_div_n   = 16'(BRAKE_DIV);
    end else if (err_valid) begin
      case (r_state)
        ST_BRAKING: begin
          if (r_count != '0) begin
            w_count_n = r_count - 1'b1;
          end else begin
            w_state_n = ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (r_div >= 16'(RECOVER_STEP)) begin
            w_div_n = r_div - 16'(RECOVER_STEP);
          end else begin
            w_div_n   = '0;
            w_state_n = ST_OFF;
          end
        end
        default: begin
          w_state_n = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_OFF;
      r_count <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_div   <= w_div_n;
    end
  end

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      r_accum   <= '0;
      r_dctrl   <= '0;
      r_dv      <= 1'b0;
      r_sat     <= 1'b0;
      r_kick    <= 1'b0;
      r_brake_q <= 1'b0;
    end else begin
      r_brake_q <= brake;
      r_dv      <= err_valid;
      r_sat     <= err_valid & w_clip;
      if (err_valid) begin
        r_accum <= w_acc_next;
        r_dctrl <= w_code;
        r_kick  <= 1'b0;
      end else if (w_rise) begin
        r_kick  <= 1'b1;
      end
    end
  end

  assign dctrl       = r_dctrl;
  assign dctrl_valid = r_dv;
  assign div_delta   = r_div;
  assign brake_state = r_state;
  assign sat         = r_sat;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Self-checking bench for pll_loop_filter against an arithmetic model.
// Expectations follow LOOP_FILTER_SAT_EN the same way as the design.
module tb_pll_loop_filter;

  logic               refclk = 1'b0;
  logic               reset;
  logic               err_valid;
  logic signed [15:0] err;
  logic               brake;
  logic signed [19:0] dctrl;
  logic               dctrl_valid;
  logic [15:0]        div_delta;
  logic [1:0]         brake_state;
  logic               sat;

  pll_loop_filter dut (
    .refclk      (refclk),
    .reset       (reset),
    .err_valid   (err_valid),
    .err         (err),
    .brake       (brake),
    .dctrl       (dctrl),
    .dctrl_valid (dctrl_valid),
    .div_delta   (div_delta),
    .brake_state (brake_state),
    .sat         (sat)
  );

  always #5 refclk = ~refclk;

  int n_cmp = 0;
  int n_bad = 0;

  longint m_acc, m_dctrl;
  int     m_st, m_cnt, m_div;
  bit     m_kick, m_bq, m_dv, m_sat;
  bit     saw_sat;

  task automatic chk(string tag, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fit(longint v, int w, output bit clip);
    longint hi, lo, m, r;
    hi   = (longint'(1) <<< (w - 1)) - 1;
    lo   = -hi - 1;
    clip = 1'b0;
`ifdef LOOP_FILTER_SAT_EN
    if (v > hi) begin clip = 1'b1; return hi; end
    if (v < lo) begin clip = 1'b1; return lo; end
    return v;
`else
    m = longint'(1) <<< w;
    r = v % m;
    if (r > hi) r = r - m;
    if (r < lo) r = r + m;
    return r;
`endif
  endfunction

  task automatic model_reset();
    m_acc = 0; m_dctrl = 0; m_st = 0; m_cnt = 0; m_div = 0;
    m_kick = 0; m_bq = 0; m_dv = 0; m_sat = 0;
  endtask

  task automatic model(bit ev, int e, bit br);
    bit rise, c1, c2;
    longint an;
    rise = br && !m_bq;
    m_bq = br;
    if (ev) begin
      an      = m_acc + e - ((m_kick || rise) ? 1666 : 0);
      m_acc   = fit(an, 24, c1);
      m_dctrl = fit(400 * longint'(e) + 60 * m_acc, 20, c2);
      m_dv    = 1;
      m_sat   = c1 | c2;
      m_kick  = 0;
    end else begin
      m_dv  = 0;
      m_sat = 0;
      if (rise) m_kick = 1;
    end
    if (rise) begin
      m_st = 1; m_cnt = 100; m_div = 300;
    end else if (ev && m_st == 1) begin
      if (m_cnt > 0) m_cnt--;
      else m_st = 2;
    end else if (ev && m_st == 2) begin
      if (m_div >= 4) m_div -= 4;
      else begin m_div = 0; m_st = 0; end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".dctrl"}, longint'(dctrl), m_dctrl);
    chk({tag, ".dv"}, longint'(dctrl_valid), longint'(m_dv));
    chk({tag, ".div"}, longint'(div_delta), longint'(m_div));
    chk({tag, ".state"}, longint'(brake_state), longint'(m_st));
    chk({tag, ".sat"}, longint'(sat), longint'(m_sat));
    if (sat) saw_sat = 1;
  endtask

  task automatic step(bit ev, int e, bit br, string tag);
    @(negedge refclk);
    err_valid = ev;
    err       = 16'(e);
    brake     = br;
    @(posedge refclk);
    model(ev, e, br);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".dctrl"}, longint'(dctrl), 0);
    chk({tag, ".dv"}, longint'(dctrl_valid), 0);
    chk({tag, ".div"}, longint'(div_delta), 0);
    chk({tag, ".state"}, longint'(brake_state), 0);
    chk({tag, ".sat"}, longint'(sat), 0);
  endtask

  initial begin
    bit br;
    int e;
    saw_sat   = 0;
    reset     = 1'b1;
    err_valid = 1'b0;
    err       = '0;
    brake     = 1'b0;
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    check_zero("reset");
    @(negedge refclk);
    reset = 1'b0;

    step(1, 1, 0, "pi0");
    chk("pi0.const", longint'(dctrl), 460);
    step(1, 1, 0, "pi1");
    chk("pi1.const", longint'(dctrl), 520);
    for (int i = 0; i < 10; i++) step(0, 0, 0, "hold");
    chk("hold.const", longint'(dctrl), 520);

    step(0, 0, 1, "rise");
    chk("rise.state", longint'(brake_state), 1);
    chk("rise.div", longint'(div_delta), 300);
    step(1, 0, 1, "kick");
    chk("kick.const", longint'(dctrl), -99840);
    for (int i = 0; i < 99; i++) step(1, 0, 1, "brk");
    chk("brk100.state", longint'(brake_state), 1);
    step(1, 0, 1, "brk101");
    chk("brk101.state", longint'(brake_state), 2);
    for (int i = 0; i < 75; i++) step(1, 0, 1, "rec");
    chk("rec75.div", longint'(div_delta), 0);
    chk("rec75.state", longint'(brake_state), 2);
    step(1, 0, 1, "rec76");
    chk("rec76.state", longint'(brake_state), 0);

    step(1, 3, 0, "rel");
    step(0, 0, 1, "rise2");
    for (int i = 0; i < 110; i++) step(1, -2, 1, "seq2");
    chk("seq2.state", longint'(brake_state), 2);
    step(1, 5, 0, "low");
    step(1, 5, 1, "rerise");
    chk("rerise.state", longint'(brake_state), 1);
    chk("rerise.div", longint'(div_delta), 300);
    for (int i = 0; i < 100; i++) step(1, 7, 1, "cnt");
    chk("cnt100.state", longint'(brake_state), 1);
    step(1, 7, 1, "cnt101");
    chk("cnt101.state", longint'(brake_state), 2);

    step(0, 0, 0, "low2");
    step(0, 0, 1, "rise3");
    step(1, 9, 1, "brk3");
    @(negedge refclk);
    brake     = 1'b0;
    err_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_zero("areset");
    model_reset();
    @(posedge refclk);
    @(negedge refclk);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) step(1, 32767, 0, "satrun");
`ifdef LOOP_FILTER_SAT_EN
    chk("satrun.code", longint'(dctrl), 524287);
    chk("satrun.saw", longint'(saw_sat), 1);
`else
    chk("satrun.saw", longint'(saw_sat), 0);
`endif

    br = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) br = ~br;
      case ($urandom_range(0, 3))
        0: e = int'($urandom_range(0, 65535)) - 32768;
        1: e = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        default: e = int'($urandom_range(0, 200)) - 100;
      endcase
      step($urandom_range(0, 3) != 0, e, br, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_loop_filter.md
# pll_loop_filter

Synthesizable proportional-integral loop filter for the all-digital PLL, clocked by the reference clock. Consumes one signed phase error per reference cycle from the phase detector and produces the registered DCO control code. Also owns the brake sequencer: the integrator kick and the feedback-divider offset that pull the DCO frequency down on demand, then ramp it back. Sits directly upstream of the DCO.

## Interface
- ERR_W, 16, phase-error width, signed
- ACC_W, 24, integrator width, signed
- CODE_W, 20, DCO control code width, signed
- KP, 400, proportional gain, integer
- KI, 60, integral gain, integer
- BRAKE_CODE, 1666, one-shot integrator subtraction applied on brake
- BRAKE_DIV, 300, initial divider offset while braking
- BRAKE_CYCLES, 100, error samples held in BRAKING
- RECOVER_STEP, 4, divider offset decrement per sample in RECOVERING

- refclk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- err_valid  in  1  err is a new sample this cycle
- err  in  ERR_W  signed phase error (target minus DCO phase)
- brake  in  1  level; rising edge requests a brake
- dctrl  out  CODE_W  signed DCO control code
- dctrl_valid  out  1  one-cycle pulse when dctrl updates
- div_delta  out  16  unsigned offset subtracted from the divider target
- brake_state  out  2  0 OFF, 1 BRAKING, 2 RECOVERING
- sat  out  1  one-cycle pulse: accum or dctrl clipped on this update

## Operation
- Reset: accum=0, dctrl=0, dctrl_valid=0, div_delta=0, brake_state=OFF, sat=0, count=0, kick_pending=0, brake_q=0.
- brake is registered into brake_q. A rise is brake & ~brake_q. On a rise, in any state: state=BRAKING, count=BRAKE_CYCLES, div_delta=BRAKE_DIV, kick_pending=1. Re-braking mid-sequence restarts the sequence.
- On err_valid:
  - accum_next = accum + sext(err) - (kick_pending ? BRAKE_CODE : 0); kick_pending clears.
  - dctrl_next = KP*err + KI*accum_next, computed at full width (ERR_W+ACC_W+8 bits), then reduced to CODE_W.
  - accum and dctrl register; dctrl_valid=1.
- Brake sequencing, advanced only on err_valid:
  - BRAKING: if count>0, count-1; else go to RECOVERING.
  - RECOVERING: if div_delta ≥ RECOVER_STEP, div_delta -= RECOVER_STEP; else div_delta=0 and go to OFF.
  - OFF: hold.
- Brake rise and err_valid in the same cycle: the brake rise wins the state, count and div_delta updates. The kick applies to this same sample (kick_pending is treated as 1 here).
- Without err_valid: accum, dctrl, state and count hold; dctrl_valid=0.

## Timing
- Latency: err sampled at edge n; dctrl and dctrl_valid visible after edge n (one refclk).
- err_valid may be asserted on every cycle; there is no backpressure.
- div_delta and brake_state change on the edge that samples the brake rise, or on the edge that samples err_valid.
- Asynchronous reset mid-sequence returns all state to the reset values immediately. Any pending kick is lost.

## Configuration
- LOOP_FILTER_SAT_EN defined:
  - accum_next clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - dctrl clamps to [-2^(CODE_W-1), 2^(CODE_W-1)-1].
  - sat pulses on any clamp.
- Undefined: both values wrap (two's-complement truncation) and sat is tied 0.

## Test plan
- Basic PI: after reset, err=1 for two valid cycles -> dctrl=460 then 520; accum=1 then 2; each dctrl_valid one cycle after its err_valid.
- Hold: err_valid low for 10 cycles after the previous test -> dctrl stays 520, dctrl_valid stays 0.
- Brake kick: from accum=2, raise brake, then err=0 valid -> accum=-1664, dctrl=-99840, brake_state=1, div_delta=300.
- Sequence: after the brake rise, 101 valid samples -> brake_state=2. Then 75 valid samples -> div_delta=0 and brake_state=0 on the 76th sample.
- Restart and reset: brake re-rises during RECOVERING -> brake_state=1, div_delta=300, count=100. Reset asserted mid-BRAKING -> all outputs return to reset values with no clock edge.
- Saturation (LOOP_FILTER_SAT_EN): preload via err=32767 repeatedly until accum=8388607 -> accum holds, dctrl=524287, sat pulses. Without the macro -> accum wraps negative and sat=0.
